alu_job_scheduler: RTL and testbench

ALU_JOB_SCHEDULER -- requirements
Module: alu_job_scheduler

---
 rtl/alu_job_scheduler_pkg.sv | 35 +++
 rtl/alu_job_scheduler_if.sv | 32 +++
 rtl/alu_job_scheduler_rr_arbiter2.sv | 33 +++
 rtl/alu_job_scheduler.sv | 113 +++++++++++
 tb/tb_alu_job_scheduler.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/alu_job_scheduler_pkg.sv
// Shared constants for the ALU job scheduler: ALU mode encodings, opcodes,
// sequencer states and the ALU control-word packing helper.
package alu_job_scheduler_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int OP_WIDTH       = 5;

   typedef enum logic [1:0] {
      MODE_READ_A = 2'b00,
      MODE_READ_B = 2'b01,
      MODE_CALC   = 2'b10,
      MODE_STATUS = 2'b11
   } alu_mode_e;

   localparam logic [OP_WIDTH-1:0] OP_PLUS   = 5'd0;
   localparam logic [OP_WIDTH-1:0] OP_MINUS  = 5'd1;
   localparam logic [OP_WIDTH-1:0] OP_AND    = 5'd2;
   localparam logic [OP_WIDTH-1:0] OP_OR     = 5'd3;
   localparam logic [OP_WIDTH-1:0] OP_NOT_A  = 5'd4;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_A = 3'd1,
      S_LOAD_B = 3'd2,
      S_CALC   = 3'd3,
      S_STATUS = 3'd4,
      S_RESP   = 3'd5
   } state_e;

   // ALU control word: [7:3] opcode, [2] reserved zero, [1:0] mode.
   function automatic logic [7:0] pack_ctrl(input logic [OP_WIDTH-1:0] op, input alu_mode_e mode);
      return {op, 1'b0, mode};
   endfunction

endpackage

// File: rtl/alu_job_scheduler_if.sv
// Job request / response / ALU-drive bundle; master is the scheduler side.
interface alu_job_scheduler_if
   import alu_job_scheduler_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
   localparam int JW = OP_WIDTH + 2*DATA_WIDTH;

   logic [1:0]            req_valid;
   logic [1:0]            req_ready;
   logic [JW-1:0]         req0_data;
   logic [JW-1:0]         req1_data;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_result;
   logic [DATA_WIDTH-1:0] rsp_status;
   logic                  rsp_id;
   logic [7:0]            alu_ctrl_o;
   logic [DATA_WIDTH-1:0] alu_data_o;
   logic [DATA_WIDTH-1:0] alu_result_i;

   modport master (
      input  req_valid, req0_data, req1_data, rsp_ready, alu_result_i,
      output req_ready, rsp_valid, rsp_result, rsp_status, rsp_id, alu_ctrl_o, alu_data_o
   );

   modport slave (
      output req_valid, req0_data, req1_data, rsp_ready, alu_result_i,
      input  req_ready, rsp_valid, rsp_result, rsp_status, rsp_id, alu_ctrl_o, alu_data_o
   );

endinterface

// File: rtl/alu_job_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer records the last grant and only
// moves when the grant is actually taken (advance).
module rr_arbiter2
   import alu_job_scheduler_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid,
   input  logic       advance,
   output logic [1:0] grant,
   output logic       grant_id
);
   logic r_last;

   // Reset value 1 makes requester 0 win the first contested grant.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_last <= 1'b1;
      end else if (advance) begin
         r_last <= grant_id;
      end
   end

   always_comb begin
      grant_id = (valid == 2'b11) ? ~r_last : valid[1];
      grant    = 2'b00;
      if (valid != 2'b00) begin
         if (grant_id) grant = 2'b10;
         else          grant = 2'b01;
      end
   end

endmodule

// File: rtl/alu_job_scheduler.sv
// Sequences one job at a time through an external ALU: load A, load B,
// calculate, read status, then holds the response until it is consumed.
module alu_job_scheduler
   import alu_job_scheduler_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int HOLD_CYCLES = 2
)(
   input  logic                  clk,
   input  logic                  rst_n,
   alu_job_scheduler_if.master   bus
);
   localparam int         JW        = OP_WIDTH + 2*DATA_WIDTH;
   localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

   state_e                r_state;
   state_e                w_next_state;
   logic [3:0]            r_cnt;
   logic [OP_WIDTH-1:0]   r_op;
   logic [DATA_WIDTH-1:0] r_a;
   logic [DATA_WIDTH-1:0] r_b;
   logic                  r_id;
   logic [DATA_WIDTH-1:0] r_result;
   logic [DATA_WIDTH-1:0] r_status;

   logic [1:0]            w_grant;
   logic                  w_grant_id;
   logic                  w_advance;
   logic                  w_last;
   logic [JW-1:0]         w_job;
   alu_mode_e             w_mode;

   // Gated by reset so req_ready is low while reset is held, even in IDLE.
   assign w_advance = (r_state == S_IDLE) && (bus.req_valid != 2'b00) && !rst_n;
   assign w_last    = (r_cnt == 4'd0);
   assign w_job     = w_grant_id ? bus.req1_data : bus.req0_data;

   rr_arbiter2 u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid    (bus.req_valid),
      .advance  (w_advance),
      .grant    (w_grant),
      .grant_id (w_grant_id)
   );

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_next_state;
         if (w_next_state != r_state) r_cnt <= HOLD_LOAD;
         else if (r_cnt != 4'd0)      r_cnt <= r_cnt - 4'd1;
      end
   end

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         S_IDLE:   if (w_advance)     w_next_state = S_LOAD_A;
         S_LOAD_A: if (w_last)        w_next_state = S_LOAD_B;
         S_LOAD_B: if (w_last)        w_next_state = S_CALC;
         S_CALC:   if (w_last)        w_next_state = S_STATUS;
         S_STATUS: if (w_last)        w_next_state = S_RESP;
         S_RESP:   if (bus.rsp_ready) w_next_state = S_IDLE;
         default:                     w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_op     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_id     <= 1'b0;
         r_result <= '0;
         r_status <= '0;
      end else begin
         if (w_advance) begin
            r_op <= w_job[JW-1 -: OP_WIDTH];
            r_a  <= w_job[2*DATA_WIDTH-1 -: DATA_WIDTH];
            r_b  <= w_job[DATA_WIDTH-1:0];
            r_id <= w_grant_id;
         end
         if (r_state == S_CALC && w_last)   r_result <= bus.alu_result_i;
         if (r_state == S_STATUS && w_last) r_status <= bus.alu_result_i;
      end
   end

   // Outside the load phases the data bus keeps showing b, which is also the
   // last value driven, so IDLE needs no separate hold register.
   always_comb begin
      w_mode = MODE_STATUS;
      bus.alu_data_o = r_b;
      unique case (r_state)
         S_LOAD_A: begin
            w_mode = MODE_READ_A;
            bus.alu_data_o = r_a;
         end
         S_LOAD_B: w_mode = MODE_READ_B;
         S_CALC:   w_mode = MODE_CALC;
         default:  w_mode = MODE_STATUS;
      endcase
      bus.alu_ctrl_o = pack_ctrl(r_op, w_mode);
      bus.req_ready  = w_advance ? w_grant : 2'b00;
      bus.rsp_valid  = (r_state == S_RESP);
      bus.rsp_result = r_result;
      bus.rsp_status = r_status;
      bus.rsp_id     = r_id;
   end

endmodule

// File: tb/tb_alu_job_scheduler.sv
// Directed bench for alu_job_scheduler with a small external ALU model
// (status = {msb, zero} of the current result).
module tb_alu_job_scheduler;
   import alu_job_scheduler_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   alu_job_scheduler_if #(.DATA_WIDTH(8)) bus ();

   alu_job_scheduler #(.DATA_WIDTH(8), .HOLD_CYCLES(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [7:0] m_a = 8'h00;
   logic [7:0] m_b = 8'h00;
   logic [7:0] m_res;

   always @(posedge clk) begin
      if (bus.alu_ctrl_o[1:0] == 2'b00)      m_a <= bus.alu_data_o;
      else if (bus.alu_ctrl_o[1:0] == 2'b01) m_b <= bus.alu_data_o;
   end

   always_comb begin
      case (bus.alu_ctrl_o[7:3])
         OP_PLUS:  m_res = m_a + m_b;
         OP_MINUS: m_res = m_a - m_b;
         OP_AND:   m_res = m_a & m_b;
         OP_OR:    m_res = m_a | m_b;
         OP_NOT_A: m_res = ~m_a;
         default:  m_res = 8'h00;
      endcase
      bus.alu_result_i = (bus.alu_ctrl_o[1:0] == 2'b11) ? {6'b0, m_res[7], (m_res == 8'h00)} : m_res;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Entered at a negedge in IDLE; returns at the negedge after the response is taken.
   task automatic do_job(input string tag, input logic [1:0] vld, input logic exp_id,
                         input logic [7:0] exp_res, input logic [7:0] exp_st,
                         input bit hold, input int stall);
      int          cyc;
      logic [15:0] modes;
      logic [1:0]  rdy_seen;
      bus.rsp_ready = (stall == 0);
      bus.req_valid = vld;
      #1;
      chk({tag, " grant"}, bus.req_ready, exp_id ? 2'b10 : 2'b01);
      @(negedge clk);
      if (!hold) bus.req_valid = 2'b00;
      cyc = 0;
      modes = '0;
      rdy_seen = '0;
      while (!bus.rsp_valid && cyc < 20) begin
         modes = {modes[13:0], bus.alu_ctrl_o[1:0]};
         rdy_seen |= bus.req_ready;
         @(negedge clk);
         cyc++;
      end
      chk({tag, " latency"}, cyc, 8);
      chk({tag, " modes"}, modes, 16'h05AF);
      chk({tag, " ready_busy"}, rdy_seen, 2'b00);
      chk({tag, " result"}, bus.rsp_result, exp_res);
      chk({tag, " status"}, bus.rsp_status, exp_st);
      chk({tag, " id"}, bus.rsp_id, exp_id);
      if (stall > 0) bus.req_valid = 2'b11;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk({tag, " stall"},
             {bus.rsp_valid, bus.req_ready, bus.rsp_result, bus.rsp_status, bus.rsp_id},
             {1'b1, 2'b00, exp_res, exp_st, exp_id});
      end
      if (stall > 0) begin
         bus.rsp_ready = 1'b1;
         bus.req_valid = 2'b00;
      end
      @(negedge clk);
      $display("job %s: id=%0d result=%h status=%h latency=%0d", tag, bus.rsp_id, bus.rsp_result, bus.rsp_status, cyc);
   endtask

   initial begin
      int         cyc;
      logic [1:0] seen;

      rst_n = 1'b1;
      bus.req_valid = 2'b11;
      bus.rsp_ready = 1'b1;
      bus.req0_data = {OP_PLUS, 8'h12, 8'h34};
      bus.req1_data = {OP_PLUS, 8'h56, 8'h78};
      repeat (2) @(negedge clk);
      #1;
      chk("rst req_ready", bus.req_ready, 2'b00);
      chk("rst rsp_valid", bus.rsp_valid, 1'b0);
      chk("rst rsp_result", bus.rsp_result, 8'h00);
      chk("rst rsp_status", bus.rsp_status, 8'h00);
      chk("rst rsp_id", bus.rsp_id, 1'b0);
      chk("rst alu_ctrl", bus.alu_ctrl_o, 8'h03);
      chk("rst alu_data", bus.alu_data_o, 8'h00);
      @(negedge clk);
      rst_n = 1'b0;
      bus.req_valid = 2'b00;
      @(negedge clk);

      bus.req0_data = {OP_MINUS, 8'd10, 8'd5};
      do_job("minus_r0", 2'b01, 1'b0, 8'h05, 8'h00, 1'b0, 0);
      chk("idle alu_ctrl", bus.alu_ctrl_o, 8'h0B);
      chk("idle alu_data", bus.alu_data_o, 8'h05);

      bus.req1_data = {OP_MINUS, 8'd5, 8'd10};
      do_job("minus_r1", 2'b10, 1'b1, 8'hFB, 8'h02, 1'b0, 0);

      rst_n = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      bus.req0_data = {OP_AND, 8'hFF, 8'h81};
      bus.req1_data = {OP_OR,  8'hFF, 8'h81};
      do_job("rr_0", 2'b11, 1'b0, 8'h81, 8'h02, 1'b1, 0);
      do_job("rr_1", 2'b11, 1'b1, 8'hFF, 8'h02, 1'b1, 0);
      do_job("rr_2", 2'b11, 1'b0, 8'h81, 8'h02, 1'b1, 0);
      do_job("rr_3", 2'b11, 1'b1, 8'hFF, 8'h02, 1'b1, 0);
      bus.req_valid = 2'b00;

      bus.req0_data = {OP_PLUS, 8'd30, 8'd12};
      do_job("stall", 2'b01, 1'b0, 8'h2A, 8'h00, 1'b0, 10);

      // Abort a job from requester 0 in CALC; the pointer must return to favour 0.
      bus.req0_data = {OP_PLUS, 8'h11, 8'h22};
      bus.req_valid = 2'b01;
      @(negedge clk);
      bus.req_valid = 2'b00;
      cyc = 0;
      while (bus.alu_ctrl_o[1:0] != 2'b10 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("abort reach_calc", cyc, 4);
      rst_n = 1'b1;
      bus.req_valid = 2'b11;
      #1;
      chk("abort req_ready", bus.req_ready, 2'b00);
      chk("abort rsp_valid", bus.rsp_valid, 1'b0);
      chk("abort rsp_result", bus.rsp_result, 8'h00);
      chk("abort rsp_status", bus.rsp_status, 8'h00);
      chk("abort rsp_id", bus.rsp_id, 1'b0);
      chk("abort alu_ctrl", bus.alu_ctrl_o, 8'h03);
      chk("abort alu_data", bus.alu_data_o, 8'h00);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      bus.req_valid = 2'b00;
      seen = 2'b00;
      repeat (10) begin
         @(negedge clk);
         seen |= {bus.rsp_valid, |bus.req_ready};
      end
      chk("abort no_response", seen, 2'b00);

      bus.req0_data = {OP_OR,  8'h0F, 8'h30};
      bus.req1_data = {OP_AND, 8'hFF, 8'hFF};
      do_job("post_rst", 2'b11, 1'b0, 8'h3F, 8'h00, 1'b0, 0);

      bus.req0_data = {OP_NOT_A, 8'hF0, 8'h00};
      do_job("not_a", 2'b01, 1'b0, 8'h0F, 8'h00, 1'b0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
